// File: rtl/proc_context_ctrl_pkg.sv
// rtl/proc_context_ctrl_pkg.sv - shared types and constants for the process context controller
package proc_context_ctrl_pkg;

    typedef enum logic [1:0] {
        OS_RUN     = 2'd0,
        SWITCH_IN  = 2'd1,
        PROC_RUN   = 2'd2,
        SWITCH_OUT = 2'd3
    } ctx_state_t;

    localparam logic [5:0] OPC_EXEC_PROG = 6'b011110;
    localparam logic [5:0] OPC_HALT_PROG = 6'b011001;
    localparam int         DEFAULT_PC_W  = 10;

endpackage

// File: rtl/proc_context_ctrl_slice_counter.sv
// rtl/proc_context_ctrl_slice_counter.sv - time-slice counter with expiry strobe
module slice_counter #(
    parameter int QUANTUM = 32,
    parameter int CNT_W   = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] count;

    assign expire = (count == LAST) & enable;

    // Wrapping on expiry keeps the count within 0..QUANTUM-1 for any QUANTUM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/proc_context_ctrl.sv
// rtl/proc_context_ctrl.sv - process-mode state and OS/process PC hand-over sequencer
module proc_context_ctrl
    import proc_context_ctrl_pkg::*;
#(
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int QUANTUM = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            Halt,
    input  logic            exec_process,
    input  logic            select_proc_reg_write,
    input  logic            select_proc_reg_read,
    input  logic            change_pc,
    input  logic            end_proc,
    input  logic [PC_W-1:0] pc_curr,
    input  logic [PC_W-1:0] pc_target,
    output logic            curr_exec_process,
    output logic            curr_select_proc_reg_write,
    output logic            curr_select_proc_reg_read,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_load_value,
    output logic [PC_W-1:0] os_ret_pc,
    output logic [PC_W-1:0] proc_pc,
    output logic            preempted,
    output logic            in_proc
);

    ctx_state_t      state, state_nxt;
    logic [2:0]      curr, curr_nxt;
    logic [PC_W-1:0] entry_pc, entry_nxt;
    logic [PC_W-1:0] os_ret_nxt, proc_nxt;
    logic [PC_W-1:0] pc_next_seq;
    logic [2:0]      dec_bits;
    logic            retire;
    logic            cnt_clear;
    logic            cnt_en;
    logic            expire;

    assign retire      = ~Halt;
    assign dec_bits    = {exec_process, select_proc_reg_write, select_proc_reg_read};
    assign pc_next_seq = pc_curr + PC_W'(1);

    assign cnt_clear = (state == SWITCH_IN);
    assign cnt_en    = (state == PROC_RUN) & retire;

    slice_counter #(
        .QUANTUM (QUANTUM)
    ) u_slice_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expire (expire)
    );

    assign curr_exec_process          = curr[2];
    assign curr_select_proc_reg_write = curr[1];
    assign curr_select_proc_reg_read  = curr[0];
    assign in_proc = (state == SWITCH_IN) | (state == PROC_RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= OS_RUN;
            curr      <= '0;
            entry_pc  <= '0;
            os_ret_pc <= '0;
            proc_pc   <= '0;
        end else begin
            state     <= state_nxt;
            curr      <= curr_nxt;
            entry_pc  <= entry_nxt;
            os_ret_pc <= os_ret_nxt;
            proc_pc   <= proc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        curr_nxt      = curr;
        entry_nxt     = entry_pc;
        os_ret_nxt    = os_ret_pc;
        proc_nxt      = proc_pc;
        pc_load       = 1'b0;
        pc_load_value = '0;
        preempted     = 1'b0;

        case (state)
            OS_RUN: begin
                if (retire) begin
                    curr_nxt = dec_bits;
                    if (change_pc) begin
                        os_ret_nxt = pc_next_seq;
                        entry_nxt  = pc_target;
                        state_nxt  = SWITCH_IN;
                    end
                end
            end
            SWITCH_IN: begin
                pc_load       = 1'b1;
                pc_load_value = entry_pc;
                state_nxt     = PROC_RUN;
            end
            PROC_RUN: begin
                // change_pc is deliberately ignored here: processes cannot nest.
                if (retire) begin
                    curr_nxt = dec_bits;
                    if (end_proc) begin
                        curr_nxt  = '0;
                        state_nxt = SWITCH_OUT;
                    end else if (expire) begin
                        curr_nxt  = '0;
                        proc_nxt  = pc_next_seq;
                        preempted = 1'b1;
                        state_nxt = SWITCH_OUT;
                    end
                end
            end
            SWITCH_OUT: begin
                pc_load       = 1'b1;
                pc_load_value = os_ret_pc;
                curr_nxt      = '0;
                state_nxt     = OS_RUN;
            end
            default: begin
                state_nxt = OS_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_context_ctrl.sv
// tb/tb_proc_context_ctrl.sv - scoreboard bench for proc_context_ctrl with QUANTUM = 4
module tb_proc_context_ctrl;

    localparam int PC_W    = 10;
    localparam int QUANTUM = 4;

    logic            clock;
    logic            reset;
    logic            Halt;
    logic            exec_process;
    logic            select_proc_reg_write;
    logic            select_proc_reg_read;
    logic            change_pc;
    logic            end_proc;
    logic [PC_W-1:0] pc_curr;
    logic [PC_W-1:0] pc_target;
    logic            curr_exec_process;
    logic            curr_select_proc_reg_write;
    logic            curr_select_proc_reg_read;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_value;
    logic [PC_W-1:0] os_ret_pc;
    logic [PC_W-1:0] proc_pc;
    logic            preempted;
    logic            in_proc;

    proc_context_ctrl #(
        .PC_W    (PC_W),
        .QUANTUM (QUANTUM)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .Halt                       (Halt),
        .exec_process               (exec_process),
        .select_proc_reg_write      (select_proc_reg_write),
        .select_proc_reg_read       (select_proc_reg_read),
        .change_pc                  (change_pc),
        .end_proc                   (end_proc),
        .pc_curr                    (pc_curr),
        .pc_target                  (pc_target),
        .curr_exec_process          (curr_exec_process),
        .curr_select_proc_reg_write (curr_select_proc_reg_write),
        .curr_select_proc_reg_read  (curr_select_proc_reg_read),
        .pc_load                    (pc_load),
        .pc_load_value              (pc_load_value),
        .os_ret_pc                  (os_ret_pc),
        .proc_pc                    (proc_pc),
        .preempted                  (preempted),
        .in_proc                    (in_proc)
    );

    typedef struct {
        bit              is_load;
        logic [PC_W-1:0] value;
        logic [PC_W-1:0] os_ret;
        logic [PC_W-1:0] pproc;
        logic [2:0]      curr;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    logic [PC_W-1:0] mp = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_load(input logic [PC_W-1:0] v, input logic [PC_W-1:0] os,
                             input logic [PC_W-1:0] pp, input logic [2:0] c);
        exp_t e;
        e.is_load = 1'b1; e.value = v; e.os_ret = os; e.pproc = pp; e.curr = c;
        sb.push_back(e);
    endtask

    task automatic push_preempt();
        exp_t e;
        e.is_load = 1'b0; e.value = '0; e.os_ret = '0; e.pproc = '0; e.curr = '0;
        sb.push_back(e);
    endtask

    // Monitor: pops an expectation whenever the DUT issues a load or a preemption pulse.
    always @(negedge clock) begin
        exp_t e;
        if (pc_load === 1'b1 || preempted === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {30'd0, pc_load, preempted}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_load) begin
                    chk("load_kind", {31'd0, pc_load}, 32'd1);
                    chk("load_value", 32'(pc_load_value), 32'(e.value));
                    chk("load_os_ret_pc", 32'(os_ret_pc), 32'(e.os_ret));
                    chk("load_proc_pc", 32'(proc_pc), 32'(e.pproc));
                    chk("load_curr", {29'd0, curr_exec_process, curr_select_proc_reg_write,
                                      curr_select_proc_reg_read}, 32'(e.curr));
                end else begin
                    chk("preempt_kind", {30'd0, preempted, pc_load}, 32'd2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dec(input logic [2:0] b);
        exec_process          = b[2];
        select_proc_reg_write = b[1];
        select_proc_reg_read  = b[0];
    endtask

    task automatic os_exec(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
        pc_curr   = pc;
        pc_target = tgt;
        change_pc = 1'b1;
        Halt      = 1'b0;
        set_dec(3'b111);
        push_load(tgt, pc + PC_W'(1), mp, 3'b111);
        step();
        change_pc = 1'b0;
        set_dec(3'b100);
    endtask

    task automatic retire(input logic [PC_W-1:0] pc, input logic endp);
        pc_curr  = pc;
        end_proc = endp;
        Halt     = 1'b0;
        step();
        end_proc = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        chk({tag, "_pc_load"}, {31'd0, pc_load}, 32'd0);
        chk({tag, "_in_proc"}, {31'd0, in_proc}, 32'd0);
        chk({tag, "_preempted"}, {31'd0, preempted}, 32'd0);
        chk({tag, "_os_ret_pc"}, 32'(os_ret_pc), 32'd0);
        chk({tag, "_proc_pc"}, 32'(proc_pc), 32'd0);
        chk({tag, "_curr"}, {29'd0, curr_exec_process, curr_select_proc_reg_write,
                             curr_select_proc_reg_read}, 32'd0);
        chk({tag, "_load_value"}, 32'(pc_load_value), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        Halt = 1'b0; change_pc = 1'b0; end_proc = 1'b0;
        set_dec(3'b000);
        pc_curr = '0; pc_target = '0;
        for (int i = 0; i < 4; i++) begin
            Halt      = 1'($urandom);
            change_pc = 1'($urandom);
            end_proc  = 1'($urandom);
            set_dec(3'($urandom));
            pc_curr   = PC_W'($urandom);
            pc_target = PC_W'($urandom);
            step();
        end
        check_idle("reset");
        step();
        Halt = 1'b0; change_pc = 1'b0; end_proc = 1'b0;
        set_dec(3'b000);
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("release_in_proc", {31'd0, in_proc}, 32'd0);
        chk("release_pc_load", {31'd0, pc_load}, 32'd0);

        // A halted change_pc must not start a switch.
        step();
        change_pc = 1'b1; Halt = 1'b1; pc_curr = 10'h030; pc_target = 10'h111;
        step();
        @(negedge clock);
        chk("halted_exec_in_proc", {31'd0, in_proc}, 32'd0);
        chk("halted_exec_os_ret", 32'(os_ret_pc), 32'd0);
        step();
        change_pc = 1'b0; Halt = 1'b0;

        // Entry then preemption after four retires with a stall in the middle.
        os_exec(10'h040, 10'h200);
        step();
        retire(10'h200, 1'b0);
        retire(10'h201, 1'b0);
        Halt = 1'b1; pc_curr = 10'h202;
        step();
        retire(10'h202, 1'b0);
        push_preempt();
        mp = 10'h204;
        push_load(10'h041, 10'h041, mp, 3'b000);
        retire(10'h203, 1'b0);
        step();

        // Voluntary exit on the third instruction.
        os_exec(10'h040, 10'h200);
        step();
        retire(10'h200, 1'b0);
        retire(10'h201, 1'b0);
        push_load(10'h041, 10'h041, mp, 3'b000);
        retire(10'h202, 1'b1);
        step();

        // end_proc coincident with expiry: no preemption, proc_pc kept.
        os_exec(10'h100, 10'h300);
        step();
        retire(10'h300, 1'b0);
        retire(10'h301, 1'b0);
        retire(10'h302, 1'b0);
        push_load(10'h101, 10'h101, mp, 3'b000);
        retire(10'h303, 1'b1);
        step();

        // Return address wraps at the top of the PC space.
        os_exec(10'h3FF, 10'h010);
        step();
        retire(10'h010, 1'b0);
        retire(10'h011, 1'b0);
        retire(10'h012, 1'b0);
        push_preempt();
        mp = 10'h014;
        push_load(10'h000, 10'h000, mp, 3'b000);
        retire(10'h013, 1'b0);
        step();

        // Reset during SWITCH_IN abandons the switch.
        os_exec(10'h050, 10'h120);
        reset = 1'b0;
        step();
        mp = '0;
        check_idle("midswitch_reset");
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("post_reset_pc_load", {31'd0, pc_load}, 32'd0);
        chk("post_reset_in_proc", {31'd0, in_proc}, 32'd0);

        step();
        step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_context_ctrl.md
# proc_context_ctrl

Sequential companion to the opcode decoder. It holds the process-mode state bits that the decoder reads back as its current-state inputs, and sequences the PC hand-over between the OS and a user process. It sits between the decoder outputs and the PC register:
- on `exec_prog` it saves the OS return address and loads the process entry PC;
- on `halt_prog`, or when the time quantum expires, it restores the OS PC;
- on preemption it also records the process resume PC.

## Interface
Parameters:
- `PC_W`, 10, program-counter width.
- `QUANTUM`, 32, number of retired process instructions before forced preemption; legal range 2..1023.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `Halt`  in  1  decoder stall; when 1, no instruction retires this cycle.
- `exec_process`, `select_proc_reg_write`, `select_proc_reg_read`  in  1 each  next-state bits from the decoder.
- `change_pc`  in  1  decoder `exec_prog` strobe.
- `end_proc`  in  1  decoder `halt_prog` strobe.
- `pc_curr`  in  PC_W  PC of the instruction currently decoding.
- `pc_target`  in  PC_W  process entry/resume address, taken from the register file.
- `curr_exec_process`, `curr_select_proc_reg_write`, `curr_select_proc_reg_read`  out  1 each  registered state, fed back to the decoder.
- `pc_load`  out  1  one-cycle PC overwrite strobe.
- `pc_load_value`  out  PC_W  value to load when `pc_load` = 1.
- `os_ret_pc`  out  PC_W  saved OS return address.
- `proc_pc`  out  PC_W  saved process resume address (written on preemption only).
- `preempted`  out  1  one-cycle pulse on quantum expiry.
- `in_proc`  out  1  high in SWITCH_IN and PROC_RUN.

## Operation
- **Retire:** a cycle with `Halt` = 0. When `Halt` = 1:
  - state, counter, saved PCs and `curr_*` all hold;
  - strobes are still evaluated only in the SWITCH states.
- **OS_RUN:**
  - On each retire, `curr_*` take the decoder bits.
  - On `change_pc` & retire:
    - latch `os_ret_pc` = `pc_curr`+1;
    - latch the `pc_target` value into an internal entry register;
    - `curr_*` take the decoder bits (all 1);
    - go to SWITCH_IN.
- **SWITCH_IN:** exactly one cycle, independent of `Halt`.
  - `pc_load` = 1, `pc_load_value` = latched entry.
  - Slice counter cleared to 0.
  - Go to PROC_RUN.
- **PROC_RUN:**
  - `curr_*` update from the decoder on each retire.
  - The counter increments on each retire.
  - `change_pc` is ignored; no nesting.
  - `end_proc` & retire → SWITCH_OUT.
  - Retire while counter = QUANTUM-1:
    - `proc_pc` = `pc_curr`+1;
    - `preempted` = 1 for that cycle;
    - go to SWITCH_OUT.
  - `end_proc` and expiry in the same cycle: `end_proc` wins. No `preempted` pulse, `proc_pc` unchanged.
- **SWITCH_OUT:** exactly one cycle.
  - `pc_load` = 1, `pc_load_value` = `os_ret_pc`.
  - All `curr_*` forced to 0.
  - Go to OS_RUN.
- **Arithmetic:** `pc_curr`+1 is modulo 2^PC_W; all-ones wraps to 0. The counter is `$clog2(QUANTUM)` bits wide and never exceeds QUANTUM-1.
- **Default:** `pc_load_value` = 0 whenever `pc_load` = 0.

## Timing
- **Reset (`reset` = 0 at an edge):**
  - state = OS_RUN;
  - every output = 0, including `os_ret_pc`, `proc_pc`, counter and entry register.
- **Reset mid-switch or mid-process:** the switch is abandoned. No `pc_load` is issued on the following cycle.
- **Entry latency:** `change_pc` retire at edge N → `pc_load` high during cycle N+1 → process runs from edge N+2.
- **Exit latency:** preemption/end retire at edge N → `pc_load` during cycle N+1.
- **Process length:** exactly QUANTUM retired instructions run before preemption. Halted cycles do not count.
- **`preempted`:** combinational with the expiring retire cycle; never high in two consecutive cycles.
- **Feedback path:** `curr_*` are registered outputs, so the decoder feedback has no combinational loop.

## Structure
- The shared package holds:
  - state enum `{OS_RUN, SWITCH_IN, PROC_RUN, SWITCH_OUT}`;
  - opcode constants for `exec_prog` (6'b011110) and `halt_prog` (6'b011001);
  - default `PC_W`.
- One sub-module, `slice_counter`: clear, enable, and `expire` = (count == QUANTUM-1) & enable.
- Everything else lives in one FSM module.

## Test plan
- Reset held low with random inputs → all outputs 0. On release, state is OS_RUN and `in_proc` = 0.
- OS at `pc_curr` = 0x040, `change_pc` = 1, `pc_target` = 0x200 → next cycle `pc_load` = 1, value 0x200, `os_ret_pc` = 0x041, all `curr_*` = 1.
- QUANTUM = 4, four retires at process PCs 0x200..0x203 with one `Halt` cycle inserted:
  - `preempted` pulses on the 0x203 retire, `proc_pc` = 0x204;
  - next cycle `pc_load` value 0x041, `curr_*` = 0.
- `end_proc` on the third process instruction → exit load 0x041, no `preempted`, `proc_pc` unchanged.
- `end_proc` coincident with quantum expiry → no `preempted`, `proc_pc` unchanged, normal exit.
- `pc_curr` = 0x3FF (PC_W = 10) with `change_pc` → `os_ret_pc` = 0x000.
- `reset` asserted during SWITCH_IN → no `pc_load` in the following cycle.
